vga_sync_receiver: RTL and testbench

//  Receiving end of the VGA timing interface: samples hsync/vsync as driven to the connector and

---
 rtl/vga_sync_receiver.sv | 174 +++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// VGA timing receiver: recovers the raster position from hsync/vsync, checks line and
// frame lengths against the expected timing, and reports lock, frame start and sync errors.
module vga_sync_receiver #(
  parameter int H_ACTIVE    = 1440,
  parameter int H_SYNC      = 152,
  parameter int H_BACK      = 232,
  parameter int H_TOTAL     = 1904,
  parameter int V_ACTIVE    = 900,
  parameter int V_SYNC      = 3,
  parameter int V_BACK      = 28,
  parameter int V_TOTAL     = 932,
  parameter int H_POL       = 0,
  parameter int V_POL       = 1,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  output logic [10:0] rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_de,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [7:0]  err_count
);

  localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
  localparam logic [11:0] H_TIMEOUT = 12'(2 * H_TOTAL - 1);
  localparam logic [11:0] H_START   = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_ACT_C   = 12'(H_ACTIVE);
  localparam logic [10:0] V_TOTAL_C = 11'(V_TOTAL);
  localparam logic [10:0] V_START   = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_C   = 11'(V_ACTIVE);
  localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);
  localparam logic [1:0]  ACT_LVL   = {V_POL != 0, H_POL != 0};

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  logic [1:0] sync_raw;
  logic [1:0] sync_lead;
  logic       hs_lead;
  logic       vs_lead;

  assign sync_raw = {vsync, hsync};

  // Bit 0 is hsync, bit 1 is vsync; both are normalised to active-high before edge detection.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic sync_q;
      logic sync_q2;
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q  <= 1'b0;
          sync_q2 <= 1'b0;
        end else begin
          sync_q  <= sync_raw[gi] ^ ~ACT_LVL[gi];
          sync_q2 <= sync_q;
        end
      end
      assign sync_lead[gi] = sync_q & ~sync_q2;
    end
  endgenerate

  assign hs_lead = sync_lead[0];
  assign vs_lead = sync_lead[1];

  state_t      state_reg;
  logic [11:0] h_cnt;
  logic [10:0] v_cnt;
  logic [3:0]  good_cnt_reg;
  logic        frame_good_reg;

  logic [11:0] h_len;
  logic [11:0] xa;
  logic [10:0] v_lines;
  logic [10:0] ya;
  logic        h_timeout;
  logic        h_viol;
  logic        v_viol;
  logic        any_viol;
  logic        frame_ok;
  logic        in_area;

  always_comb begin
    h_len     = h_cnt + 12'd1;
    h_timeout = !hs_lead && (h_cnt == H_TIMEOUT);
    // Line count including a coincident hsync edge, so a simultaneous vsync sees the new value.
    v_lines   = v_cnt;
    if (hs_lead && (v_cnt != 11'h7FF))
      v_lines = v_cnt + 11'd1;
    h_viol    = (state_reg != SEARCH) && ((hs_lead && (h_len != H_TOTAL_C)) || h_timeout);
    v_viol    = vs_lead && (v_lines != V_TOTAL_C);
    any_viol  = h_viol || v_viol;
    frame_ok  = frame_good_reg && !any_viol;
    xa        = h_cnt - H_START;
    ya        = v_cnt - V_START;
    in_area   = (xa < H_ACT_C) && (ya < V_ACT_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= SEARCH;
      h_cnt          <= 12'd0;
      v_cnt          <= 11'd0;
      good_cnt_reg   <= 4'd0;
      frame_good_reg <= 1'b0;
      rx_x           <= 11'd0;
      rx_y           <= 10'd0;
      rx_de          <= 1'b0;
      frame_start    <= 1'b0;
      locked         <= 1'b0;
      sync_err       <= 1'b0;
      err_count      <= 8'd0;
    end else begin
      h_cnt <= (hs_lead || h_timeout) ? 12'd0 : h_len;
      v_cnt <= vs_lead ? 11'd0 : v_lines;

      if (vs_lead)
        frame_good_reg <= !h_viol;
      else if (h_viol)
        frame_good_reg <= 1'b0;

      frame_start <= 1'b0;
      sync_err    <= 1'b0;

      case (state_reg)
        SEARCH: begin
          if (vs_lead) begin
            state_reg    <= MEASURE;
            good_cnt_reg <= 4'd0;
          end
        end
        MEASURE: begin
          if (vs_lead && frame_ok) begin
            if (good_cnt_reg + 4'd1 >= LOCK_C) begin
              state_reg    <= LOCKED;
              locked       <= 1'b1;
              good_cnt_reg <= 4'd0;
            end else begin
              good_cnt_reg <= good_cnt_reg + 4'd1;
            end
          end else if (vs_lead || any_viol) begin
            good_cnt_reg <= 4'd0;
          end
        end
        LOCKED: begin
          if (any_viol) begin
            sync_err  <= 1'b1;
            locked    <= 1'b0;
            state_reg <= SEARCH;
            if (err_count != 8'hFF)
              err_count <= err_count + 8'd1;
          end else if (vs_lead) begin
            frame_start <= 1'b1;
          end
        end
        default: state_reg <= SEARCH;
      endcase

      if (in_area) begin
        rx_x  <= xa[10:0];
        rx_y  <= ya[9:0];
        rx_de <= locked;
      end else begin
        rx_x  <= 11'd0;
        rx_y  <= 10'd0;
        rx_de <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Scoreboard bench for vga_sync_receiver using a miniature raster so many frames fit in the run.
module tb_vga_sync_receiver;

  localparam int HA = 3, HS = 1, HB = 1, HT = 6;
  localparam int VA = 3, VS = 1, VB = 1, VT = 6;
  localparam int RST_LINE = 3;
  localparam int RST_H    = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync;
  logic        vsync;
  logic [10:0] rx_x;
  logic [9:0]  rx_y;
  logic        rx_de;
  logic        frame_start;
  logic        locked;
  logic        sync_err;
  logic [7:0]  err_count;

  int n_cmp      = 0;
  int n_bad      = 0;
  int err_pulses = 0;
  int fs_pulses  = 0;
  bit sync_err_prev = 1'b0;
  int exp_q[$];

  always #5 clk = ~clk;

  vga_sync_receiver #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
    .H_POL(0), .V_POL(1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync),
    .rx_x(rx_x), .rx_y(rx_y), .rx_de(rx_de), .frame_start(frame_start),
    .locked(locked), .sync_err(sync_err), .err_count(err_count)
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Monitor: every data-enable cycle pops the next expected pixel.
  always @(negedge clk) begin
    if (rx_de) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL de_unexpected: got x=%0d y=%0d, want no pixel", rx_x, rx_y);
      end else begin
        int e;
        e = exp_q.pop_front();
        if ((int'(rx_x) != (e & 16'hFFFF)) || (int'(rx_y) != (e >> 16))) begin
          n_bad++;
          $display("FAIL pixel: got x=%0d y=%0d, want x=%0d y=%0d",
                   rx_x, rx_y, e & 16'hFFFF, e >> 16);
        end else begin
          $display("pix  x=%0d y=%0d", rx_x, rx_y);
        end
      end
    end
    if (sync_err) begin
      err_pulses++;
      check("sync_err_width", int'(sync_err_prev), 0);
    end
    if (frame_start)
      fs_pulses++;
    sync_err_prev = sync_err;
  end

  task automatic drive(input logic r, input logic h, input logic v);
    @(posedge clk);
    #1;
    rst   = r;
    hsync = h;
    vsync = v;
  endtask

  task automatic send_frame(input int nlines, input int short_line, input bit want_de,
                            input int rst_line);
    bit rst_pending = 1'b0;
    if (want_de)
      for (int y = 0; y < VA; y++)
        for (int x = 0; x < HA; x++)
          exp_q.push_back((y << 16) | x);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == short_line) ? HT - 1 : HT;
      for (int h = 0; h < len; h++) begin
        bit hit;
        hit = (l == rst_line) && (h == RST_H);
        drive(hit, (h < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b1 : 1'b0);
        if (rst_pending) begin
          @(negedge clk);
          check("rst_mid_locked", int'(locked), 0);
          check("rst_mid_de", int'(rx_de), 0);
          check("rst_mid_err_count", int'(err_count), 0);
          rst_pending = 1'b0;
        end
        if (hit) begin
          @(negedge clk);
          check("pre_rst_de", int'(rx_de), 1);
          check("pre_rst_locked", int'(locked), 1);
          rst_pending = 1'b1;
        end
      end
    end
  endtask

  task automatic normal_frames(input int n, input bit want_de);
    for (int i = 0; i < n; i++)
      send_frame(VT, -1, want_de, -1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; hsync = 1'b1; vsync = 1'b0;
    for (int i = 0; i < 4; i++)
      drive(1'b1, (i % 2) == 0, (i % 2) == 1);
    @(negedge clk);
    check("reset_rx_x", int'(rx_x), 0);
    check("reset_rx_y", int'(rx_y), 0);
    check("reset_rx_de", int'(rx_de), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_sync_err", int'(sync_err), 0);
    check("reset_err_count", int'(err_count), 0);
    drive(1'b0, 1'b1, 1'b0);

    // Ideal timing: lock on the third vsync edge, then full frames of pixels.
    normal_frames(2, 1'b0);
    @(negedge clk);
    check("lock_before_3rd_edge", int'(locked), 0);
    normal_frames(1, 1'b1);
    @(negedge clk);
    check("lock_at_3rd_edge", int'(locked), 1);
    normal_frames(2, 1'b1);
    @(negedge clk);
    check("frame_start_count", fs_pulses, 2);
    check("ideal_pixels_drained", int'(exp_q.size()), 0);
    check("ideal_err_count", int'(err_count), 0);

    // One line shortened by a clock while locked.
    send_frame(VT, 1, 1'b0, -1);
    @(negedge clk);
    check("short_line_err_count", int'(err_count), 1);
    check("short_line_pulses", err_pulses, 1);
    check("short_line_unlocked", int'(locked), 0);
    normal_frames(2, 1'b0);
    @(negedge clk);
    check("short_relock_early", int'(locked), 0);
    normal_frames(1, 1'b1);
    @(negedge clk);
    check("short_relock", int'(locked), 1);

    // hsync held inactive long enough to hit the line timeout.
    for (int i = 0; i < 2 * HT + 2; i++)
      drive(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("timeout_err_count", int'(err_count), 2);
    check("timeout_unlocked", int'(locked), 0);
    normal_frames(2, 1'b0);
    normal_frames(1, 1'b1);
    @(negedge clk);
    check("timeout_relock", int'(locked), 1);

    // Frame one line short.
    send_frame(VT - 1, -1, 1'b1, -1);
    normal_frames(1, 1'b0);
    @(negedge clk);
    check("vshort_err_count", int'(err_count), 3);
    check("vshort_pulses", err_pulses, 3);
    check("vshort_unlocked", int'(locked), 0);
    normal_frames(2, 1'b0);
    normal_frames(1, 1'b1);
    @(negedge clk);
    check("vshort_relock", int'(locked), 1);
    check("pre_rst_pixels_drained", int'(exp_q.size()), 0);

    // Reset pulse in the middle of the active area while locked.
    send_frame(VT, -1, 1'b1, RST_LINE);
    exp_q.delete();
    @(negedge clk);
    check("post_rst_unlocked", int'(locked), 0);
    normal_frames(2, 1'b0);

    // Repeated frame-length violations, relocking in between, saturate the error counter.
    for (int it = 0; it < 300; it++) begin
      send_frame(VT - 1, -1, 1'b1, -1);
      normal_frames(3, 1'b0);
      @(negedge clk);
      check("err_count_sat", int'(err_count), (it + 1 > 255) ? 255 : it + 1);
    end
    check("total_err_pulses", err_pulses, 303);
    check("final_pixels_drained", int'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
